// File: rtl/multi_dataflow_package.sv
// Shared types and default widths for the multi_dataflow kernel adapter control path.
package multi_dataflow_package;

    localparam int unsigned DEF_LEN_W  = 16;
    localparam int unsigned DEF_TILE_W = 16;
    localparam int unsigned DEF_CONF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONF    = 3'd1,
        ST_STREAM  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } ctrl_state_t;

    typedef struct packed {
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_TILE_W-1:0] tiles;
        logic [DEF_CONF_W-1:0] conf_id;
    } ctrl_cfg_t;

    typedef struct packed {
        logic in1;
        logic in2;
        logic out;
    } ctrl_stream_req_t;

    function automatic logic all_granted(input ctrl_stream_req_t g);
        return g.in1 & g.in2 & g.out;
    endfunction

endpackage

// File: rtl/multi_dataflow_stream_req.sv
// Single streamer request/grant handshake: request held from open until its grant is sampled.
module multi_dataflow_stream_req (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic open_i,
    input  logic gnt_i,
    output logic req_o,
    output logic granted_o
);

    logic req_r;
    logic seen_r;

    // Request latch and grant-seen flag; a new open re-arms both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_r  <= 1'b0;
            seen_r <= 1'b0;
        end else if (clear_i) begin
            req_r  <= 1'b0;
            seen_r <= 1'b0;
        end else if (open_i) begin
            req_r  <= 1'b1;
            seen_r <= 1'b0;
        end else if (req_r && gnt_i) begin
            req_r  <= 1'b0;
            seen_r <= 1'b1;
        end else begin
            req_r  <= req_r;
            seen_r <= seen_r;
        end
    end

    assign req_o     = req_r;
    // Includes the grant arriving this cycle so the FSM can leave STREAM without a bubble.
    assign granted_o = seen_r | (req_r & gnt_i);

endmodule

// File: rtl/multi_dataflow_ctrl_fsm.sv
// Job sequencer: configures the datapath, opens streams per tile, starts the kernel and
// counts its done pulses, then raises a completion event.
module multi_dataflow_ctrl_fsm
    import multi_dataflow_package::*;
#(
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned TILE_W      = DEF_TILE_W,
    parameter int unsigned CONF_W      = DEF_CONF_W,
    parameter int unsigned CONF_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              job_start_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [TILE_W-1:0] cfg_tiles_i,
    input  logic [CONF_W-1:0] cfg_conf_id_i,
    output logic [CONF_W-1:0] conf_id_o,
    output logic              conf_valid_o,
    output logic              in1_req_o,
    output logic              in2_req_o,
    output logic              out_req_o,
    input  logic              in1_gnt_i,
    input  logic              in2_gnt_i,
    input  logic              out_gnt_i,
    input  logic              out_done_i,
    output logic              kernel_start_o,
    input  logic              kernel_done_i,
    output logic              busy_o,
    output logic              evt_done_o,
    output logic              err_o,
    output logic [TILE_W-1:0] tile_idx_o
);

    localparam int unsigned CC_W = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
    localparam logic [CC_W-1:0] CONF_LAST = CC_W'(CONF_CYCLES - 1);

    ctrl_state_t       state_r;
    logic [LEN_W-1:0]  len_r;
    logic [TILE_W-1:0] tiles_r;
    logic [CONF_W-1:0] conf_id_r;
    logic [TILE_W-1:0] tile_cnt_r;
    logic [LEN_W-1:0]  out_cnt_r;
    logic [CC_W-1:0]   conf_cnt_r;
    logic              conf_valid_r;
    logic              kernel_start_r;
    logic              busy_r;
    logic              evt_done_r;
    logic              err_r;

    ctrl_stream_req_t  req_s;
    ctrl_stream_req_t  gnt_s;
    ctrl_stream_req_t  granted_s;
    logic              open_s;
    logic              last_tile_s;

    assign gnt_s       = '{in1: in1_gnt_i, in2: in2_gnt_i, out: out_gnt_i};
    assign last_tile_s = (tile_cnt_r == (tiles_r - TILE_W'(1)));

    // Open the streams in the cycle before STREAM is entered, so requests rise with the state.
    always_comb begin
        open_s = 1'b0;
        if (state_r == ST_CONF && conf_cnt_r == CONF_LAST) begin
            open_s = 1'b1;
        end else if (state_r == ST_NEXT && !last_tile_s) begin
            open_s = 1'b1;
        end else begin
            open_s = 1'b0;
        end
    end

    multi_dataflow_stream_req u_req_in1 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .open_i    (open_s),
        .gnt_i     (gnt_s.in1),
        .req_o     (req_s.in1),
        .granted_o (granted_s.in1)
    );

    multi_dataflow_stream_req u_req_in2 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .open_i    (open_s),
        .gnt_i     (gnt_s.in2),
        .req_o     (req_s.in2),
        .granted_o (granted_s.in2)
    );

    multi_dataflow_stream_req u_req_out (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .open_i    (open_s),
        .gnt_i     (gnt_s.out),
        .req_o     (req_s.out),
        .granted_o (granted_s.out)
    );

    // Sequencer state, counters and registered control outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= ST_IDLE;
            len_r          <= LEN_W'(0);
            tiles_r        <= TILE_W'(0);
            conf_id_r      <= CONF_W'(0);
            tile_cnt_r     <= TILE_W'(0);
            out_cnt_r      <= LEN_W'(0);
            conf_cnt_r     <= CC_W'(0);
            conf_valid_r   <= 1'b0;
            kernel_start_r <= 1'b0;
            busy_r         <= 1'b0;
            evt_done_r     <= 1'b0;
            err_r          <= 1'b0;
        end else if (clear_i) begin
            state_r        <= ST_IDLE;
            len_r          <= LEN_W'(0);
            tiles_r        <= TILE_W'(0);
            conf_id_r      <= CONF_W'(0);
            tile_cnt_r     <= TILE_W'(0);
            out_cnt_r      <= LEN_W'(0);
            conf_cnt_r     <= CC_W'(0);
            conf_valid_r   <= 1'b0;
            kernel_start_r <= 1'b0;
            busy_r         <= 1'b0;
            evt_done_r     <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            kernel_start_r <= 1'b0;
            evt_done_r     <= 1'b0;
            err_r          <= err_r | (kernel_done_i & (state_r != ST_COMPUTE));
            case (state_r)
                ST_IDLE: begin
                    if (job_start_i) begin
                        len_r      <= cfg_len_i;
                        tiles_r    <= cfg_tiles_i;
                        conf_id_r  <= cfg_conf_id_i;
                        tile_cnt_r <= TILE_W'(0);
                        busy_r     <= 1'b1;
                        if (cfg_len_i == LEN_W'(0) || cfg_tiles_i == TILE_W'(0)) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r      <= ST_CONF;
                            conf_valid_r <= 1'b1;
                            conf_cnt_r   <= CC_W'(0);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONF: begin
                    if (conf_cnt_r == CONF_LAST) begin
                        conf_valid_r <= 1'b0;
                        state_r      <= ST_STREAM;
                    end else begin
                        conf_cnt_r <= conf_cnt_r + CC_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (all_granted(granted_s)) begin
                        state_r        <= ST_COMPUTE;
                        kernel_start_r <= 1'b1;
                        out_cnt_r      <= LEN_W'(0);
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_COMPUTE: begin
                    if (kernel_done_i) begin
                        if (out_cnt_r == (len_r - LEN_W'(1))) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            out_cnt_r <= out_cnt_r + LEN_W'(1);
                        end
                    end else begin
                        state_r <= ST_COMPUTE;
                    end
                end
                ST_DRAIN: begin
                    if (out_done_i) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_NEXT: begin
                    if (last_tile_s) begin
                        state_r    <= ST_DONE;
                        evt_done_r <= 1'b1;
                    end else begin
                        tile_cnt_r <= tile_cnt_r + TILE_W'(1);
                        state_r    <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    // An empty job arrives here with the event not yet raised; hold one cycle to raise it.
                    if (evt_done_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        evt_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign conf_id_o      = conf_id_r;
    assign conf_valid_o   = conf_valid_r;
    assign in1_req_o      = req_s.in1;
    assign in2_req_o      = req_s.in2;
    assign out_req_o      = req_s.out;
    assign kernel_start_o = kernel_start_r;
    assign busy_o         = busy_r;
    assign evt_done_o     = evt_done_r;
    assign err_o          = err_r;
    assign tile_idx_o     = tile_cnt_r;

endmodule

// File: tb/tb_multi_dataflow_ctrl_fsm.sv
// Self-checking bench for multi_dataflow_ctrl_fsm: job table, directed corner sequences and random jobs.
module tb_multi_dataflow_ctrl_fsm;

    localparam int LEN_W  = 16;
    localparam int TILE_W = 16;
    localparam int CONF_W = 8;
    localparam int CONF_CYCLES = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              job_start_i = 1'b0;
    logic [LEN_W-1:0]  cfg_len_i = '0;
    logic [TILE_W-1:0] cfg_tiles_i = '0;
    logic [CONF_W-1:0] cfg_conf_id_i = '0;
    logic [CONF_W-1:0] conf_id_o;
    logic              conf_valid_o;
    logic              in1_req_o, in2_req_o, out_req_o;
    logic              in1_gnt_i = 1'b0, in2_gnt_i = 1'b0, out_gnt_i = 1'b0;
    logic              out_done_i = 1'b0;
    logic              kernel_start_o;
    logic              kernel_done_i = 1'b0;
    logic              busy_o, evt_done_o, err_o;
    logic [TILE_W-1:0] tile_idx_o;

    multi_dataflow_ctrl_fsm #(
        .LEN_W(LEN_W), .TILE_W(TILE_W), .CONF_W(CONF_W), .CONF_CYCLES(CONF_CYCLES)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .job_start_i(job_start_i),
        .cfg_len_i(cfg_len_i), .cfg_tiles_i(cfg_tiles_i), .cfg_conf_id_i(cfg_conf_id_i),
        .conf_id_o(conf_id_o), .conf_valid_o(conf_valid_o),
        .in1_req_o(in1_req_o), .in2_req_o(in2_req_o), .out_req_o(out_req_o),
        .in1_gnt_i(in1_gnt_i), .in2_gnt_i(in2_gnt_i), .out_gnt_i(out_gnt_i),
        .out_done_i(out_done_i), .kernel_start_o(kernel_start_o), .kernel_done_i(kernel_done_i),
        .busy_o(busy_o), .evt_done_o(evt_done_o), .err_o(err_o), .tile_idx_o(tile_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Event counters observed away from the active edge.
    int kstart_cnt = 0, evt_cnt = 0, conf_cyc_cnt = 0, conf_bad_cnt = 0, req_cyc_cnt = 0;
    logic [CONF_W-1:0] exp_conf = '0;
    always @(negedge clk_i) begin
        if (kernel_start_o) kstart_cnt = kstart_cnt + 1;
        if (evt_done_o) evt_cnt = evt_cnt + 1;
        if (conf_valid_o) conf_cyc_cnt = conf_cyc_cnt + 1;
        if (conf_valid_o && conf_id_o != exp_conf) conf_bad_cnt = conf_bad_cnt + 1;
        if (in1_req_o || in2_req_o || out_req_o) req_cyc_cnt = req_cyc_cnt + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {conf_id_o, conf_valid_o, in1_req_o, in2_req_o, out_req_o, kernel_start_o,
                     busy_o, evt_done_o, err_o, tile_idx_o}, 0);
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    typedef struct {
        int len; int tiles; int conf; int d1; int d2; int d3; int gap; bit poke;
        int exp_kstart; int exp_conf_cyc;
    } job_t;

    // Drives one job end to end, acting as the streamers and the kernel, and checks timing.
    task automatic run_job(input job_t j);
        int kc0, e0, c0, b0, q0, t_start, mx, n, exp_req_cyc;
        kc0 = kstart_cnt; e0 = evt_cnt; c0 = conf_cyc_cnt; b0 = conf_bad_cnt; q0 = req_cyc_cnt;
        exp_conf = j.conf[CONF_W-1:0];
        mx = max3(j.d1, j.d2, j.d3);
        step();
        cfg_len_i = j.len[LEN_W-1:0];
        cfg_tiles_i = j.tiles[TILE_W-1:0];
        cfg_conf_id_i = j.conf[CONF_W-1:0];
        job_start_i = 1'b1;
        t_start = cyc;
        step();
        job_start_i = 1'b0;
        if (j.len == 0 || j.tiles == 0) begin
            check("empty evt T+1", evt_done_o, 0);
            check("empty busy T+1", busy_o, 1);
            step();
            check("empty evt T+2", evt_done_o, 1);
            step();
            check("empty evt T+3", evt_done_o, 0);
            check("empty busy T+3", busy_o, 0);
        end else begin
            check("conf_valid T+1", conf_valid_o, 1);
            check("conf_id T+1", conf_id_o, j.conf);
            step();
            check("conf_valid T+2", conf_valid_o, 1);
            exp_req_cyc = t_start + 3;
            for (int t = 0; t < j.tiles; t++) begin
                n = 0;
                while (!in1_req_o && n < 40) begin step(); n++; end
                if (!in1_req_o) begin
                    check("req timeout", 0, 1);
                    return;
                end
                check("req start cycle", cyc, exp_req_cyc);
                for (int k = 0; k <= mx; k++) begin
                    check("in1_req level", in1_req_o, (k <= j.d1));
                    check("in2_req level", in2_req_o, (k <= j.d2));
                    check("out_req level", out_req_o, (k <= j.d3));
                    check("kstart in stream", kernel_start_o, 0);
                    in1_gnt_i = (k == j.d1);
                    in2_gnt_i = (k == j.d2);
                    out_gnt_i = (k == j.d3);
                    if (j.poke && t == 0 && k == 0) begin
                        job_start_i = 1'b1;
                        cfg_conf_id_i = ~j.conf[CONF_W-1:0];
                        cfg_len_i = 16'd9;
                        cfg_tiles_i = 16'd9;
                    end
                    step();
                    in1_gnt_i = 1'b0; in2_gnt_i = 1'b0; out_gnt_i = 1'b0;
                    job_start_i = 1'b0;
                end
                check("kernel_start", kernel_start_o, 1);
                check("tile_idx", tile_idx_o, t);
                check("reqs low in compute", {in1_req_o, in2_req_o, out_req_o}, 0);
                for (int d = 0; d < j.len; d++) begin
                    kernel_done_i = 1'b1;
                    step();
                    kernel_done_i = 1'b0;
                    if (d == 0) check("kstart single", kernel_start_o, 0);
                    repeat (j.gap) step();
                end
                out_done_i = 1'b1;
                exp_req_cyc = cyc + 2;
                step();
                out_done_i = 1'b0;
                check("evt D+1", evt_done_o, 0);
                check("busy D+1", busy_o, 1);
                if (t == j.tiles - 1) begin
                    step();
                    check("evt D+2", evt_done_o, 1);
                    step();
                    check("evt D+3", evt_done_o, 0);
                    check("busy D+3", busy_o, 0);
                end
            end
        end
        check("kstart count", kstart_cnt - kc0, j.exp_kstart);
        check("evt count", evt_cnt - e0, 1);
        check("conf cycles", conf_cyc_cnt - c0, j.exp_conf_cyc);
        check("conf id stable", conf_cyc_cnt - c0 > 0 ? conf_bad_cnt - b0 : 0, 0);
        check("conf_id latched", conf_id_o, j.conf);
        check("err clean", err_o, 0);
        if (j.exp_kstart == 0) check("no req on empty", req_cyc_cnt - q0, 0);
    endtask

    job_t jobs[6];
    job_t rj;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        jobs[0] = '{len: 4, tiles: 1, conf: 8'h03, d1: 0, d2: 0, d3: 0, gap: 1, poke: 1'b0, exp_kstart: 1, exp_conf_cyc: 2};
        jobs[1] = '{len: 2, tiles: 3, conf: 8'h5a, d1: 0, d2: 3, d3: 5, gap: 0, poke: 1'b0, exp_kstart: 3, exp_conf_cyc: 2};
        jobs[2] = '{len: 0, tiles: 3, conf: 8'h11, d1: 0, d2: 0, d3: 0, gap: 0, poke: 1'b0, exp_kstart: 0, exp_conf_cyc: 0};
        jobs[3] = '{len: 3, tiles: 0, conf: 8'h22, d1: 0, d2: 0, d3: 0, gap: 0, poke: 1'b0, exp_kstart: 0, exp_conf_cyc: 0};
        jobs[4] = '{len: 1, tiles: 2, conf: 8'h07, d1: 2, d2: 0, d3: 1, gap: 2, poke: 1'b1, exp_kstart: 2, exp_conf_cyc: 2};
        jobs[5] = '{len: 3, tiles: 1, conf: 8'hc3, d1: 4, d2: 2, d3: 0, gap: 0, poke: 1'b0, exp_kstart: 1, exp_conf_cyc: 2};

        #1;
        check_all_zero("reset outputs");
        step();
        rst_ni = 1'b1;
        step();
        check_all_zero("idle after reset");

        foreach (jobs[i]) run_job(jobs[i]);

        // kernel_done outside COMPUTE raises a sticky error that only clear removes.
        kernel_done_i = 1'b1;
        step();
        kernel_done_i = 1'b0;
        check("err set", err_o, 1);
        repeat (3) step();
        check("err sticky", err_o, 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("err cleared", err_o, 0);

        // clear in COMPUTE after one of four dones.
        exp_conf = 8'h44;
        cfg_len_i = 16'd4; cfg_tiles_i = 16'd1; cfg_conf_id_i = 8'h44;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        repeat (2) step();
        check("clr req up", in1_req_o & in2_req_o & out_req_o, 1);
        in1_gnt_i = 1'b1; in2_gnt_i = 1'b1; out_gnt_i = 1'b1;
        step();
        in1_gnt_i = 1'b0; in2_gnt_i = 1'b0; out_gnt_i = 1'b0;
        check("clr kstart", kernel_start_o, 1);
        kernel_done_i = 1'b1;
        step();
        kernel_done_i = 1'b0;
        clear_i = 1'b1;
        e0 = evt_cnt;
        step();
        clear_i = 1'b0;
        check_all_zero("after clear");
        repeat (5) step();
        check("no evt after clear", evt_cnt - e0, 0);
        check("idle after clear", busy_o, 0);
        run_job(jobs[0]);

        // Asynchronous reset in the middle of STREAM.
        exp_conf = 8'h66;
        cfg_len_i = 16'd2; cfg_tiles_i = 16'd2; cfg_conf_id_i = 8'h66;
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        repeat (2) step();
        check("rst req up", in1_req_o, 1);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("async reset");
        step();
        rst_ni = 1'b1;
        repeat (5) step();
        check("stay idle after reset", {busy_o, in1_req_o, conf_valid_o}, 0);
        run_job(jobs[1]);

        // Random jobs against the rule-based expectation.
        for (int i = 0; i < 20; i++) begin
            rj.len = $urandom_range(1, 4);
            rj.tiles = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) rj.len = 0;
            if ($urandom_range(0, 9) == 0) rj.tiles = 0;
            rj.conf = $urandom_range(0, 255);
            rj.d1 = $urandom_range(0, 4);
            rj.d2 = $urandom_range(0, 4);
            rj.d3 = $urandom_range(0, 4);
            rj.gap = $urandom_range(0, 2);
            rj.poke = ($urandom_range(0, 3) == 0);
            rj.exp_kstart = (rj.len == 0 || rj.tiles == 0) ? 0 : rj.tiles;
            rj.exp_conf_cyc = (rj.len == 0 || rj.tiles == 0) ? 0 : CONF_CYCLES;
            run_job(rj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
